hsv_multi_threshold: RTL
========================

# hsv_multi_threshold

Parametrised multi-channel HSV threshold and row packer. It sits after the RGB-to-HSV converter in the camera pipeline and classifies each pixel against NUM_CH independently programmable colour windows. Each channel's results are packed into one IMG_W-bit mask word per image row, and every completed row is written to the row-mask BRAM with a one-cycle write strobe. It supersedes the single-window, fixed-640×480 thresholder.

## Interface
- IMG_W, 640, pixels per row (bits per channel word)
- IMG_H, 480, rows per frame; BRAM depth
- NUM_CH, 2, number of independent colour windows (1..4)
- CHW, $clog2(NUM_CH) min 1, channel select width
- clk  in  1  pipeline clock; the block has one clock
- rst_n  in  1  reset, asynchronous, active-low
- hsv_h  in  9  hue, 0..359
- hsv_s  in  9  saturation
- hsv_v  in  8  value
- hsv_valid  in  1  pixel qualifier, one pixel per cycle when high
- frame_done_in  in  1  end-of-frame pulse, one cycle
- thr_ch  in  CHW  channel being programmed
- thr_type  in  3  0 hue_hi, 1 hue_lo, 2 sat_min, 3 val_min, 4 hue_mode (data[0]); 5..7 ignored
- thr_data  in  9  threshold value; val_min uses [7:0]
- thr_vld  in  1  one-cycle write strobe
- row_data  out  NUM_CH*IMG_W  channel c mask at [c*IMG_W +: IMG_W]; bit x is pixel column x
- row_addr  out  $clog2(IMG_H)  BRAM row address
- wea  out  1  BRAM write enable, one-cycle pulse per row
- row_pop  out  NUM_CH*$clog2(IMG_W+1)  per-channel count of set bits in the row
- frame_done_out  out  1  frame-done pulse, aligned after the last row write

## Operation
- Thresholds are double-buffered.
  - A thr_vld write updates the shadow register set, one cycle after the strobe.
  - Shadow values copy to the active set only in S_IDLE, so no frame ever uses mixed thresholds.
- Reset values, all channels: hue_hi=310, hue_lo=50, sat_min=95, val_min=80, hue_mode=0.
- Pixel match for channel c requires all three terms:
  - Hue: with hue_mode=0 (wrap window), h>hue_hi OR h<hue_lo. With hue_mode=1 (band), hue_lo<=h<=hue_hi.
  - Saturation: s>sat_min.
  - Value: v>val_min.
  - All compares are unsigned, 9-bit; v is zero-extended.
- Column counter col (0..IMG_W-1): the match bit for each channel is written to bit col, then col increments.
- Row counter row_addr (0..IMG_H-1).
- FSM:
  - S_IDLE: load active thresholds; clear col, row_addr and all row_data. Go to S_ROW on the next cycle unless frame_done_in is high.
  - S_ROW: accept pixels. On the pixel with col==IMG_W-1, set col to 0 and assert wea on the next cycle. After the row with row_addr==IMG_H-1 completes, go to S_DROP.
  - S_DROP: ignore hsv_valid; wea stays 0.
  - Any state: frame_done_in goes to S_IDLE. A partially filled row is discarded, with no wea.
- row_data bits from the previous row are overwritten, not cleared, between rows. Every bit is rewritten before the next wea.
- Reset mid-frame: all outputs return to reset values immediately. The active and shadow thresholds return to their defaults.

## Timing
- Pixel to mask bit: 1 cycle, registered.
- Last pixel of a row at cycle N produces wea=1 at N+1, with row_data and row_pop complete and row_addr equal to this row.
- row_addr increments at N+2.
- Back-to-back hsv_valid is supported. The first pixel of the next row, at N+1, is written to bit 0 without corrupting the word being written; a staging register is acceptable.
- frame_done_out: frame_done_in delayed by exactly 2 cycles, one-cycle pulse. It always follows any wea of that frame.
- thr_vld and hsv_valid in the same cycle are independent. A threshold write on the same cycle as the S_IDLE load takes effect at the next frame.
- Reset values: row_data=0, row_addr=0, wea=0, row_pop=0, frame_done_out=0, FSM in S_IDLE.

## Configuration
- HSV_ROW_POPCOUNT_EN:
  - Defined: row_pop holds per-channel set-bit counts, valid during wea. Counters are incremented per matching pixel and cleared at row start.
  - Undefined: no counter logic; row_pop is constant 0.

## Test plan
- Defaults, NUM_CH=1, IMG_W=8, IMG_H=4: row of h=0,s=100,v=100 (8 pixels) -> wea one cycle after pixel 8, row_data=8'hFF, row_addr=0, row_pop=8.
- Channel 1 programmed to hue_mode=1, lo=100, hi=140; pixels h=120,s=200,v=200 -> ch1 bits=1, ch0 bits=0.
- Threshold write mid-frame -> current frame unchanged; next frame after frame_done_in uses the new value.
- 5 full rows with IMG_H=4 -> wea for addr 0..3 only; 5th row dropped.
- frame_done_in after 3 pixels of a row -> no wea; frame_done_out 2 cycles later; next frame starts at addr 0, col 0.
- Continuous hsv_valid across a row boundary, then rst_n low mid-row -> correct masks for both rows; all outputs 0 asynchronously on reset.

Source files
------------

// File: rtl/hsv_multi_threshold.sv
// ============================================================================
// Module   : hsv_multi_threshold
// Purpose  : Classifies HSV pixels against NUM_CH colour windows and packs the
//            per-channel match bits into one mask word per row for a row BRAM.
// Option   : HSV_ROW_POPCOUNT_EN adds per-channel set-bit counts on row_pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_multi_threshold #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int NUM_CH = 2,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [8:0]                           hsv_h,
  input  logic [8:0]                           hsv_s,
  input  logic [7:0]                           hsv_v,
  input  logic                                 hsv_valid,
  input  logic                                 frame_done_in,
  input  logic [CHW-1:0]                       thr_ch,
  input  logic [2:0]                           thr_type,
  input  logic [8:0]                           thr_data,
  input  logic                                 thr_vld,
  output logic [NUM_CH*IMG_W-1:0]              row_data,
  output logic [$clog2(IMG_H)-1:0]             row_addr,
  output logic                                 wea,
  output logic [NUM_CH*$clog2(IMG_W+1)-1:0]    row_pop,
  output logic                                 frame_done_out
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = $clog2(IMG_W + 1);

  localparam logic [CW-1:0] c_col_last   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_last   = RW'(IMG_H - 1);
  localparam logic [8:0]    c_def_hue_hi = 9'd310;
  localparam logic [8:0]    c_def_hue_lo = 9'd50;
  localparam logic [8:0]    c_def_sat    = 9'd95;
  localparam logic [7:0]    c_def_val    = 8'd80;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0][8:0] sh_hue_hi_q, sh_hue_hi_d, act_hue_hi_q, act_hue_hi_d;
  logic [NUM_CH-1:0][8:0] sh_hue_lo_q, sh_hue_lo_d, act_hue_lo_q, act_hue_lo_d;
  logic [NUM_CH-1:0][8:0] sh_sat_q,    sh_sat_d,    act_sat_q,    act_sat_d;
  logic [NUM_CH-1:0][7:0] sh_val_q,    sh_val_d,    act_val_q,    act_val_d;
  logic [NUM_CH-1:0]      sh_mode_q,   sh_mode_d,   act_mode_q,   act_mode_d;

  logic [NUM_CH-1:0][IMG_W-1:0] row_data_q, row_data_d;
  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_addr_q, row_addr_d;
  logic                         wea_q, wea_d;
  logic [1:0]                   fd_pipe_q, fd_pipe_d;
  logic [NUM_CH-1:0]            pix_match;
  logic                         pix_take;

  // Shadow set takes host writes at any time; it only reaches the pixel path via S_IDLE.
  always_comb begin
    sh_hue_hi_d = sh_hue_hi_q;
    sh_hue_lo_d = sh_hue_lo_q;
    sh_sat_d    = sh_sat_q;
    sh_val_d    = sh_val_q;
    sh_mode_d   = sh_mode_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (thr_vld && (thr_ch == CHW'(c))) begin
        case (thr_type)
          3'd0:    sh_hue_hi_d[c] = thr_data;
          3'd1:    sh_hue_lo_d[c] = thr_data;
          3'd2:    sh_sat_d[c]    = thr_data;
          3'd3:    sh_val_d[c]    = thr_data[7:0];
          3'd4:    sh_mode_d[c]   = thr_data[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pix_match = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pix_match[c] = (act_mode_q[c]
                        ? ((hsv_h >= act_hue_lo_q[c]) && (hsv_h <= act_hue_hi_q[c]))
                        : ((hsv_h >  act_hue_hi_q[c]) || (hsv_h <  act_hue_lo_q[c])))
                     && (hsv_s > act_sat_q[c])
                     && ({1'b0, hsv_v} > {1'b0, act_val_q[c]});
    end
  end

  assign pix_take = (state_q == S_ROW) && !frame_done_in && hsv_valid;

  // The finished word is held for the wea cycle only; the next row's pixel
  // then lands on bit 0, so no separate staging copy is needed.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_addr_d   = row_addr_q;
    row_data_d   = row_data_q;
    wea_d        = 1'b0;
    act_hue_hi_d = act_hue_hi_q;
    act_hue_lo_d = act_hue_lo_q;
    act_sat_d    = act_sat_q;
    act_val_d    = act_val_q;
    act_mode_d   = act_mode_q;
    fd_pipe_d    = {fd_pipe_q[0], frame_done_in};

    if (wea_q && (row_addr_q != c_row_last)) begin
      row_addr_d = row_addr_q + RW'(1);
    end

    case (state_q)
      S_IDLE: begin
        act_hue_hi_d = sh_hue_hi_q;
        act_hue_lo_d = sh_hue_lo_q;
        act_sat_d    = sh_sat_q;
        act_val_d    = sh_val_q;
        act_mode_d   = sh_mode_q;
        col_d        = '0;
        row_addr_d   = '0;
        row_data_d   = '0;
        if (!frame_done_in) begin
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        if (frame_done_in) begin
          state_d = S_IDLE;
        end else if (hsv_valid) begin
          for (int c = 0; c < NUM_CH; c++) begin
            row_data_d[c][col_q] = pix_match[c];
          end
          if (col_q == c_col_last) begin
            col_d = '0;
            wea_d = 1'b1;
            if (row_addr_q == c_row_last) begin
              state_d = S_DROP;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DROP: begin
        if (frame_done_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sh_hue_hi_q  <= {NUM_CH{c_def_hue_hi}};
      sh_hue_lo_q  <= {NUM_CH{c_def_hue_lo}};
      sh_sat_q     <= {NUM_CH{c_def_sat}};
      sh_val_q     <= {NUM_CH{c_def_val}};
      sh_mode_q    <= '0;
      act_hue_hi_q <= {NUM_CH{c_def_hue_hi}};
      act_hue_lo_q <= {NUM_CH{c_def_hue_lo}};
      act_sat_q    <= {NUM_CH{c_def_sat}};
      act_val_q    <= {NUM_CH{c_def_val}};
      act_mode_q   <= '0;
      row_data_q   <= '0;
      col_q        <= '0;
      row_addr_q   <= '0;
      wea_q        <= 1'b0;
      fd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      sh_hue_hi_q  <= sh_hue_hi_d;
      sh_hue_lo_q  <= sh_hue_lo_d;
      sh_sat_q     <= sh_sat_d;
      sh_val_q     <= sh_val_d;
      sh_mode_q    <= sh_mode_d;
      act_hue_hi_q <= act_hue_hi_d;
      act_hue_lo_q <= act_hue_lo_d;
      act_sat_q    <= act_sat_d;
      act_val_q    <= act_val_d;
      act_mode_q   <= act_mode_d;
      row_data_q   <= row_data_d;
      col_q        <= col_d;
      row_addr_q   <= row_addr_d;
      wea_q        <= wea_d;
      fd_pipe_q    <= fd_pipe_d;
    end
  end

`ifdef HSV_ROW_POPCOUNT_EN
  logic [NUM_CH-1:0][PW-1:0] pop_q, pop_d;

  // Column 0 reloads rather than clears, so the count shown during wea survives
  // a back-to-back first pixel of the next row.
  always_comb begin
    pop_d = pop_q;
    if (state_q == S_IDLE) begin
      pop_d = '0;
    end else if (pix_take) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pop_d[c] = (col_q == '0) ? PW'(pix_match[c]) : pop_q[c] + PW'(pix_match[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q <= '0;
    end else begin
      pop_q <= pop_d;
    end
  end

  assign row_pop = pop_q;
`else
  assign row_pop = '0;
`endif

  assign row_data       = row_data_q;
  assign row_addr       = row_addr_q;
  assign wea            = wea_q;
  assign frame_done_out = fd_pipe_q[1];

endmodule

`default_nettype wire
